isqrt_pipe: RTL and testbench

ISQRT_PIPE -- requirements
Module: isqrt_pipe

---
 rtl/isqrt_pipe.sv | 87 ++++++++
 tb/tb_isqrt_pipe.sv | 93 +++++++++
 2 files changed

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: pipelined restoring integer square root, y = floor(sqrt(x)), BITS_PER_STAGE root bits per stage.
// Define ISQRT_PIPE_DATA_RST_EN to also asynchronously clear the datapath registers.
module isqrt_pipe #(
  parameter int BITS_PER_STAGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);
  localparam int L = 16 / BITS_PER_STAGE;
  logic [L:0]  vld_q, vld_d;
  logic [15:0] root_q [0:L];
  logic [15:0] root_d [0:L];
  logic [17:0] rem_q  [0:L];
  logic [17:0] rem_d  [0:L];
  logic [31:0] rad_q  [0:L];
  logic [31:0] rad_d  [0:L];
  // Stage 0 only captures the radicand; stages 1..L each resolve BITS_PER_STAGE root bits.
  always_comb begin
    logic [15:0] rt;
    logic [17:0] rm;
    logic [31:0] rd;
    logic [19:0] s;
    logic [17:0] t;
    logic        ge;
    vld_d = {vld_q[L-1:0], x_vld};
    root_d[0] = '0;
    rem_d[0] = '0;
    rad_d[0] = x;
    rt = '0;
    rm = '0;
    rd = '0;
    s = '0;
    t = '0;
    ge = 1'b0;
    for (int i = 1; i <= L; i++) begin
      rt = root_q[i-1];
      rm = rem_q[i-1];
      rd = rad_q[i-1];
      for (int j = 0; j < BITS_PER_STAGE; j++) begin
        s = {rm, rd[31:30]};
        // A non-negative trial always fits the 18-bit remainder, so the sign test is done as a compare.
        ge = s >= {2'b00, rt, 2'b01};
        t = s[17:0] - {rt, 2'b01};
        rm = ge ? t : s[17:0];
        rt = {rt[14:0], ge};
        rd = {rd[29:0], 2'b00};
      end
      root_d[i] = rt;
      rem_d[i] = rm;
      rad_d[i] = rd;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) vld_q <= '0;
    else vld_q <= vld_d;
`ifdef ISQRT_PIPE_DATA_RST_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i <= L; i++) begin
        root_q[i] <= '0;
        rem_q[i] <= '0;
        rad_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= L; i++)
        if (vld_d[i]) begin
          root_q[i] <= root_d[i];
          rem_q[i] <= rem_d[i];
          rad_q[i] <= rad_d[i];
        end
    end
`else
  always_ff @(posedge clk)
    for (int i = 0; i <= L; i++)
      if (vld_d[i]) begin
        root_q[i] <= root_d[i];
        rem_q[i] <= rem_d[i];
        rad_q[i] <= rad_d[i];
      end
`endif
  assign y_vld = vld_q[L];
  assign y = root_q[L];
endmodule

// File: tb/tb_isqrt_pipe.sv
// tb_isqrt_pipe: directed checks of isqrt_pipe latency, results, bubbles and reset.
module tb_isqrt_pipe;
  localparam int L = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_vld = 1'b0;
  logic [31:0] x = '0;
  logic        y_vld;
  logic [15:0] y;
  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] q[$];
  isqrt_pipe #(.BITS_PER_STAGE(1)) dut (
    .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(y_vld), .y(y)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One clock edge: drive an argument, then check the output due from L edges earlier.
  task automatic step(input logic v, input logic [31:0] xv, input logic [15:0] ey);
    logic [16:0] e;
    x_vld = v;
    x = xv;
    q.push_back({v, ey});
    @(posedge clk);
    #1;
    if (q.size() > L) begin
      e = q.pop_front();
      chk("y_vld", {31'b0, y_vld}, {31'b0, e[16]});
      if (e[16]) chk($sformatf("y(%0d)", e[15:0]), {16'b0, y}, {16'b0, e[15:0]});
    end else chk("fill_vld", {31'b0, y_vld}, 32'd0);
  endtask
  initial begin
    #2;
    chk("rst_vld0", {31'b0, y_vld}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld1", {31'b0, y_vld}, 32'd0);
`ifdef ISQRT_PIPE_DATA_RST_EN
    chk("rst_y", {16'b0, y}, 32'd0);
`endif
    rst = 1'b0;
    step(1, 32'd16, 16'd4);
    repeat (L + 3) step(0, 32'd0, 16'd0);
    step(1, 32'd0, 16'd0);
    step(1, 32'hFFFF_FFFF, 16'hFFFF);
    step(1, 32'd4294836225, 16'd65535);
    step(1, 32'd4294836224, 16'd65534);
    step(1, 32'd17, 16'd4);
    step(0, 32'hDEAD_BEEF, 16'd0);
    step(0, 32'h1234_5678, 16'd0);
    step(1, 32'd15, 16'd3);
    step(1, 32'd1000000, 16'd1000);
    step(1, 32'd1, 16'd1);
    step(1, 32'd2, 16'd1);
    step(1, 32'd3, 16'd1);
    step(1, 32'd4, 16'd2);
    step(1, 32'd99, 16'd9);
    step(1, 32'd100, 16'd10);
    step(1, 32'd65536, 16'd256);
    step(1, 32'h4000_0000, 16'd32768);
    step(1, 32'h3FFF_FFFF, 16'd32767);
    step(1, 32'd2147483648, 16'd46340);
    step(1, 32'd123456789, 16'd11111);
    repeat (L + 2) step(0, 32'd0, 16'd0);
    for (int i = 0; i < 5; i++) step(1, 32'd100 + i, 16'd10);
    x_vld = 1'b1;
    x = 32'd200;
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_vld", {31'b0, y_vld}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      x = 32'd300 + i;
      chk("inrst_vld", {31'b0, y_vld}, 32'd0);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    q.delete();
    step(1, 32'd81, 16'd9);
    repeat (L + 4) step(0, 32'd0, 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
